// File: rtl/accum_cmd_pkg.sv
// Shared types for the accumulator command sequencer.
// Opcodes, queued command layout and sequencer FSM states.
package accum_cmd_pkg;

    localparam int CMD_CNT_W = 8;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_LOAD = 2'b01,
        OP_RUN  = 2'b10,
        OP_RSVD = 2'b11
    } opcode_e;

    typedef struct packed {
        opcode_e               op;
        logic [7:0]            data;
        logic [CMD_CNT_W-1:0]  count;
    } cmd_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/accum_cmd_fifo.sv
// Synchronous command FIFO, extra pointer MSB separates full from empty.
// Storage is not reset; only the pointers are.
module accum_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_l,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_full;
    logic         w_empty;
    logic         w_wr_en;
    logic         w_rd_en;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_en = i_push && !w_full;
    assign w_rd_en = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/accum_cmd_seq.sv
// Command sequencer feeding the load/increment accumulator.
// Queued commands expand into registered per-cycle load/in_data/inc drive.
module accum_cmd_seq
    import accum_cmd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = CMD_CNT_W
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             load,
    output logic [7:0]       in_data,
    output logic [7:0]       inc,
    output logic             done,
    output logic             busy,
    output logic             err
);

    state_e           r_state;
    logic [CNT_W-1:0] r_remain;
    logic             r_load;
    logic [7:0]       r_in_data;
    logic [7:0]       r_inc;
    logic             r_done;
    logic             r_err;

    state_e           w_state_nx;
    logic [CNT_W-1:0] w_remain_nx;
    logic             w_load_nx;
    logic [7:0]       w_in_data_nx;
    logic [7:0]       w_inc_nx;
    logic             w_done_nx;
    logic             w_err_nx;

    cmd_t             w_push_cmd;
    cmd_t             w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic [CNT_W-1:0] w_head_cnt;

    // Ready is forced low while reset is held so nothing is accepted.
    assign cmd_ready = reset_l && !w_full;
    assign w_push    = cmd_valid && cmd_ready;

    always_comb begin
        w_push_cmd       = '0;
        w_push_cmd.op    = opcode_e'(cmd_op);
        w_push_cmd.data  = cmd_data;
        w_push_cmd.count = CMD_CNT_W'(cmd_count);
    end

    accum_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(cmd_t))
    ) u_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .i_push  (w_push),
        .i_wdata (w_push_cmd),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_cnt = CNT_W'(w_head.count);
    assign w_last     = (r_remain == CNT_W'(1));
    assign w_pop      = !w_empty &&
                        ((r_state == S_IDLE) || w_last);

    always_comb begin
        w_state_nx   = r_state;
        w_remain_nx  = r_remain;
        w_load_nx    = r_load;
        w_in_data_nx = r_in_data;
        w_inc_nx     = r_inc;
        w_done_nx    = 1'b0;
        w_err_nx     = 1'b0;
        if (w_pop) begin
            w_state_nx   = S_EXEC;
            w_load_nx    = 1'b0;
            w_in_data_nx = 8'h00;
            w_inc_nx     = 8'h00;
            w_remain_nx  = CNT_W'(1);
            unique case (w_head.op)
                OP_LOAD: begin
                    w_load_nx    = 1'b1;
                    w_in_data_nx = w_head.data;
                end
                OP_RUN: begin
                    // A zero count retires as one idle cycle.
                    if (w_head_cnt != '0) begin
                        w_inc_nx    = w_head.data;
                        w_remain_nx = w_head_cnt;
                    end
                end
                OP_HOLD: begin
                    if (w_head_cnt != '0) begin
                        w_remain_nx = w_head_cnt;
                    end
                end
                OP_RSVD: begin
                    w_err_nx = 1'b1;
                end
            endcase
            w_done_nx = (w_remain_nx == CNT_W'(1));
        end else if (r_state == S_EXEC) begin
            if (w_last) begin
                w_state_nx   = S_IDLE;
                w_remain_nx  = '0;
                w_load_nx    = 1'b0;
                w_in_data_nx = 8'h00;
                w_inc_nx     = 8'h00;
            end else begin
                w_remain_nx = r_remain - CNT_W'(1);
                w_done_nx   = (r_remain == CNT_W'(2));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state   <= S_IDLE;
            r_remain  <= '0;
            r_load    <= 1'b0;
            r_in_data <= 8'h00;
            r_inc     <= 8'h00;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_remain  <= w_remain_nx;
            r_load    <= w_load_nx;
            r_in_data <= w_in_data_nx;
            r_inc     <= w_inc_nx;
            r_done    <= w_done_nx;
            r_err     <= w_err_nx;
        end
    end

    assign load    = r_load;
    assign in_data = r_in_data;
    assign inc     = r_inc;
    assign done    = r_done;
    assign err     = r_err;
    assign busy    = (r_state == S_EXEC) || !w_empty;

endmodule

// File: tb/tb_accum_cmd_seq.sv
// Bench for accum_cmd_seq: directed and random commands against a
// queue-based model of per-command drive expansion and the accumulator.
module tb_accum_cmd_seq;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] cmd_count = 8'h00;
    logic       load;
    logic [7:0] in_data;
    logic [7:0] inc;
    logic       done;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    accum_cmd_seq #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .load      (load),
        .in_data   (in_data),
        .inc       (inc),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    // Downstream accumulator driven by the DUT.
    logic [7:0] r_acc;
    always @(posedge clk or negedge reset_l) begin
        if (!reset_l) r_acc <= 8'h00;
        else if (load) r_acc <= in_data;
        else r_acc <= r_acc + inc;
    end

    typedef struct packed {
        logic       ld;
        logic [7:0] din;
        logic [7:0] inc;
        logic       dn;
        logic       er;
    } drv_t;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] count;
    } mcmd_t;

    drv_t       exp_q[$];
    mcmd_t      pend_q[$];
    logic [7:0] exp_acc = 8'h00;
    bit         accepted;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic void expand(input mcmd_t c);
        if (c.op == 2'b01) begin
            exp_q.push_back('{1'b1, c.data, 8'h00, 1'b1, 1'b0});
        end else if (c.op == 2'b11) begin
            exp_q.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b1});
        end else if (c.count == 8'h00) begin
            exp_q.push_back('{1'b0, 8'h00, 8'h00, 1'b1, 1'b0});
        end else begin
            for (int i = 0; i < int'(c.count); i++) begin
                exp_q.push_back('{1'b0, 8'h00,
                    (c.op == 2'b10) ? c.data : 8'h00,
                    (i == int'(c.count) - 1), 1'b0});
            end
        end
    endfunction

    function automatic void model_clear();
        exp_q.delete();
        pend_q.delete();
        exp_acc = 8'h00;
    endfunction

    // Called just after a rising edge; inputs are still the pre-edge values.
    task automatic model_edge();
        drv_t d;
        bit   rdy;
        accepted = 1'b0;
        if (!reset_l) begin
            model_clear();
        end else begin
            rdy = (pend_q.size() < DEPTH);
            d = '0;
            if (exp_q.size() > 0) d = exp_q.pop_front();
            exp_acc = d.ld ? d.din : exp_acc + d.inc;
            if (exp_q.size() == 0 && pend_q.size() > 0)
                expand(pend_q.pop_front());
            if (cmd_valid && rdy) begin
                pend_q.push_back('{cmd_op, cmd_data, cmd_count});
                accepted = 1'b1;
            end
        end
    endtask

    task automatic compare();
        drv_t d;
        d = (exp_q.size() > 0) ? exp_q[0] : '0;
        chk("load", 32'(load), 32'(d.ld));
        chk("in_data", 32'(in_data), 32'(d.din));
        chk("inc", 32'(inc), 32'(d.inc));
        chk("done", 32'(done), 32'(d.dn));
        chk("err", 32'(err), 32'(d.er));
        chk("busy", 32'(busy),
            32'(exp_q.size() > 0 || pend_q.size() > 0));
        chk("cmd_ready", 32'(cmd_ready),
            32'(reset_l && pend_q.size() < DEPTH));
        chk("out_data", 32'(r_acc), 32'(exp_acc));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] data,
                        input logic [7:0] count);
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = count;
        n = 0;
        do begin
            step();
            n++;
        end while (!accepted && n < 400);
        if (!accepted) chk("send_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic drain();
        int n;
        cmd_valid = 1'b0;
        n = 0;
        while ((exp_q.size() > 0 || pend_q.size() > 0) && n < 2000) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(n < 2000), 32'd1);
        step();
    endtask

    initial begin
        int r;
        #1;
        compare();
        step();
        step();
        reset_l = 1'b1;
        #1;
        compare();

        send(2'b01, 8'h5A, 8'd0);
        idle(3);

        send(2'b01, 8'h10, 8'd0);
        send(2'b10, 8'h03, 8'd4);
        idle(7);

        send(2'b10, 8'h07, 8'd10);
        send(2'b01, 8'h20, 8'd0);
        send(2'b10, 8'h01, 8'd2);
        send(2'b00, 8'h00, 8'd1);
        send(2'b10, 8'h05, 8'd3);
        drain();

        send(2'b10, 8'hFF, 8'd0);
        send(2'b00, 8'h00, 8'd3);
        idle(6);

        send(2'b01, 8'h11, 8'd0);
        send(2'b11, 8'h22, 8'd5);
        send(2'b01, 8'h33, 8'd0);
        idle(4);

        send(2'b10, 8'h01, 8'd255);
        drain();

        send(2'b10, 8'h02, 8'd8);
        send(2'b01, 8'h44, 8'd0);
        send(2'b00, 8'h00, 8'd2);
        idle(3);
        #2;
        reset_l = 1'b0;
        #1;
        model_clear();
        compare();
        step();
        step();
        reset_l = 1'b1;
        #1;
        compare();
        idle(12);

        repeat (80) begin
            r = $urandom_range(0, 9);
            if (r < 3)
                send(2'b01, 8'($urandom), 8'($urandom));
            else if (r < 6)
                send(2'b10, 8'($urandom), 8'($urandom_range(0, 5)));
            else if (r < 9)
                send(2'b00, 8'($urandom), 8'($urandom_range(0, 5)));
            else
                send(2'b11, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/accum_cmd_seq.md
Name: accum_cmd_seq

Overview:
- Command sequencer directly upstream of the 8-bit load/increment accumulator.
- Accepts queued commands over a valid/ready interface and drives the accumulator's load, in_data and inc inputs cycle by cycle.
- Supported commands: load a value, run an increment for N cycles, hold for N cycles.
- Decouples software or testbench command issue from accumulator timing; queues up to DEPTH commands.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, at least 2.
- CNT_W, 8, width of the per-command cycle count.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset_l  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_op  input  2  opcode: 00 HOLD, 01 LOAD, 10 RUN, 11 reserved.
- cmd_data  input  8  LOAD value, or RUN increment.
- cmd_count  input  CNT_W  cycle count for RUN/HOLD; ignored for LOAD.
- load  output  1  to accumulator load.
- in_data  output  8  to accumulator in_data.
- inc  output  8  to accumulator inc.
- done  output  1  one-cycle pulse on the last drive cycle of each command.
- busy  output  1  FSM in EXEC or FIFO non-empty.
- err  output  1  one-cycle pulse when a reserved opcode is retired.

Behaviour:
- Reset (reset_l=0, asynchronous):
  - load=0, in_data=0, inc=0, done=0, err=0, busy=0.
  - FIFO emptied; FSM to IDLE; cmd_ready=0 while reset is asserted, 1 on the first cycle after release.
- Push: on a posedge with cmd_valid && cmd_ready, write {op, data, count}.
  - No push when full, even if a pop occurs on the same edge.
  - cmd_valid while !cmd_ready is held off by the sender; contents must stay stable.
- All outputs are registered. Idle drive is load=0, inc=0, so the accumulator holds its value.
- FSM states:
  - IDLE: on a posedge with FIFO non-empty, pop the head, set the drive registers, go to EXEC.
  - EXEC: a remaining counter decrements each cycle. On the last cycle, if the FIFO is non-empty, pop the next command at that same edge (no bubble). Otherwise return to IDLE with drive at zero.
- Latency: a command accepted at edge N on an empty, idle block drives outputs from edge N+1. The accumulator first samples it at edge N+2.
- LOAD: one cycle of load=1, in_data=cmd_data, inc=0. done is high in that cycle.
- RUN: count cycles of load=0, inc=cmd_data, in_data=0. done is high in the final cycle.
- HOLD: count cycles of load=0, inc=0.
- Count 0 (RUN or HOLD): retired as a single cycle with load=0, inc=0, done=1.
- Reserved op 11: retired as one cycle of zero drive with done=1 and err=1.
- Remaining counter is CNT_W bits. count=2^CNT_W-1 gives exactly that many cycles, with no wrap.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full and empty are derived from the pointer MSB compare.
- Reset asserted mid-command aborts the command and drops queued entries. No done pulse is issued for the aborted command.

Decomposition:
- Package accum_cmd_pkg holds:
  - typedef enum opcode_e {OP_HOLD, OP_LOAD, OP_RUN, OP_RSVD};
  - typedef struct cmd_t {opcode_e op; logic [7:0] data; logic [CNT_W-1:0] count};
  - FSM state enum {S_IDLE, S_EXEC}.
- One sub-module, accum_cmd_fifo: synchronous FIFO with async active-low reset, push/pop/full/empty, parameterised by DEPTH and payload width.
- The FSM and drive registers stay in accum_cmd_seq.

Test Plan:
- Reset, then LOAD 0x5A -> load=1, in_data=0x5A for exactly one cycle starting at the edge after acceptance; done pulses once; downstream out_data=0x5A.
- LOAD 0x10 then RUN inc=0x03 count=4 issued back-to-back -> 1 load cycle then 4 inc cycles with no gap; out_data sequence 0x10,0x13,0x16,0x19,0x1C; done pulses twice.
- Push 5 commands with DEPTH=4 while the first is RUN count=10 -> cmd_ready drops after the 4th is queued, rises after the first pop; all 5 execute in order.
- RUN inc=0xFF count=0 and HOLD count=3 -> single zero-drive cycle with done; then 3 cycles inc=0; out_data unchanged throughout.
- Reserved op 11 between two LOADs -> one zero-drive cycle, err and done pulse together; both LOADs still execute.
- Assert reset_l=0 asynchronously mid-RUN count=8 with 2 entries queued -> outputs go to 0 immediately; after release busy=0, cmd_ready=1, no stale commands execute.
